// File: rtl/mult8x8_seq_ctrl.sv
// rtl/mult8x8_seq_ctrl.sv - 8x8 unsigned multiplier built from one 4x4 product unit over four steps
// Valid/ready on both sides; outputs depend only on registered state.
module mult8x8_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [3:0]  shamt;
  logic [15:0] partial;

  // Step bit 0 picks the high multiplicand nibble, bit 1 the high multiplier nibble.
  always_comb begin
    nib_a   = step_q[0] ? a_q[7:4] : a_q[3:0];
    nib_b   = step_q[1] ? b_q[7:4] : b_q[3:0];
    pp      = {4'b0000, nib_a} * {4'b0000, nib_b};
    case (step_q)
      2'd0:    shamt = 4'd0;
      2'd3:    shamt = 4'd8;
      default: shamt = 4'd4;
    endcase
    partial = {8'h00, pp} << shamt;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      acc_q   <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    p         = out_valid ? acc_q : 16'h0000;
  end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// tb/tb_mult8x8_seq_ctrl.sv - directed vector bench for mult8x8_seq_ctrl
// Inputs driven and outputs sampled at the falling edge.
module tb_mult8x8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] vp;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  mult8x8_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // junk=1 keeps a conflicting operand pair asserted from handshake until return to IDLE.
  task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vp,
                       input int hold, input bit junk, input bit check_lat);
    int n;
    logic [15:0] held;
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    a = va;
    b = vb;
    out_ready = 1'b0;
    step();
    if (junk) begin
      a = 8'hFF;
      b = 8'hFF;
    end else begin
      in_valid = 1'b0;
      a = 8'h5A;
      b = 8'hC3;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      if (p !== 16'h0000) chk("p_zero_while_invalid", p, 0);
      out_ready = n[0];
      step();
      n++;
    end
    out_ready = 1'b0;
    if (check_lat) chk("latency_edges", n, 4);
    chk("out_valid", out_valid, 1);
    chk("product", p, vp);
    held = p;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_p", p, held);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_p", p, 0);
    chk("post_busy", busy, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    vecs[0] = '{8'h12, 8'h34, 16'h03A8, 0};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0};
    vecs[2] = '{8'h00, 8'hB7, 16'h0000, 1};
    vecs[3] = '{8'h01, 8'hFF, 16'h00FF, 0};
    vecs[4] = '{8'h9C, 8'h47, 16'h2B44, 10};
    vecs[5] = '{8'h80, 8'h80, 16'h4000, 2};
    vecs[6] = '{8'h10, 8'h10, 16'h0100, 0};
    vecs[7] = '{8'hA5, 8'h5A, 16'h3A02, 3};

    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 8'h77;
    b = 8'h77;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_no_capture_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vp, vecs[i].hold, 1'b0, 1'b1);
    end

    // Conflicting pair during the operation must not leak in.
    do_op(8'h0F, 8'h0F, 16'h00E1, 1, 1'b1, 1'b1);
    do_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, 1'b1);

    // Reset during MUL step 2 discards the operation.
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_p", p, 0);
    chk("midrst_busy", busy, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (out_valid || busy) seen++;
      end
      chk("midrst_no_stale", seen, 0);
    end

    // Random pairs with random backpressure.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic [15:0] rp;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rp = 16'(ra) * 16'(rb);
      do_op(ra, rb, rp, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult8x8_seq_ctrl.md
MULT8X8_SEQ_CTRL -- requirements
Module: mult8x8_seq_ctrl

Interface
REQ-001 No parameters; all widths fixed (8-bit operands, 16-bit product).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  controller can accept an operand pair.
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  p holds a completed product.
REQ-009 out_ready  input  1  consumer accepts p.
REQ-010 p  output  16  unsigned product a*b.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Block SHALL contain exactly one 4x4 unsigned combinational product unit (8-bit result), time-shared over four steps per operation; no other multiplier.
REQ-013 States SHALL be IDLE, MUL, DONE; MUL SHALL carry a 2-bit step counter (0..3).
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready at an edge, a and b SHALL be captured into internal registers, accumulator cleared to 0, step=0, next state MUL; otherwise remain IDLE.
REQ-016 MUL step 0: acc += a[3:0]*b[3:0]; step 1: acc += (a[7:4]*b[3:0])<<4; step 2: acc += (a[3:0]*b[7:4])<<4; step 3: acc += (a[7:4]*b[7:4])<<8; one step per cycle.
REQ-017 Accumulator SHALL be 16 bits; no overflow possible (max 0xFE01); addition SHALL be unsigned, no truncation of shifted partials below bit 15.
REQ-018 After step 3 the next state SHALL be DONE; step counter SHALL wrap to 0.
REQ-019 Latency: handshake at edge N -> out_valid first high in the cycle following edge N+4.
REQ-020 DONE: p SHALL equal the accumulator and stay stable while out_valid=1 and out_ready=0 (any number of cycles).
REQ-021 DONE with out_ready=1 at an edge SHALL return to IDLE; in_ready high in the following cycle; minimum issue interval 6 cycles.
REQ-022 p SHALL read 0 whenever out_valid=0.
REQ-023 in_valid, a, b changes while busy=1 SHALL be ignored and SHALL NOT affect the in-flight result.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 No combinational path from in_valid or out_ready to any output.

Reset
REQ-026 rst_n=0 at an edge SHALL force state IDLE, step=0, acc=0, operand registers=0, regardless of current state.
REQ-027 Outputs during/after reset: in_ready=1, out_valid=0, busy=0, p=0.
REQ-028 Reset mid-operation (MUL or DONE) SHALL discard the operation; no out_valid pulse SHALL follow for it.
REQ-029 rst_n=0 with in_valid=1 SHALL NOT capture operands.

Verification
REQ-030 a=0x12, b=0x34, out_ready=1 -> out_valid high 5th cycle after handshake, p=0x03A8, then in_ready=1 next cycle.
REQ-031 a=0xFF, b=0xFF -> p=0xFE01; a=0x00, b=0xB7 -> p=0x0000; a=0x01, b=0xFF -> p=0x00FF.
REQ-032 a=0x9C, b=0x47, out_ready held 0 for 10 cycles -> out_valid and p=0x2B44 stable all 10 cycles; completes on first out_ready=1 edge.
REQ-033 Handshake a=0x0F,b=0x0F, then drive in_valid=1 a=0xFF,b=0xFF during MUL -> p=0x00E1; second pair accepted only after return to IDLE.
REQ-034 rst_n=0 for one cycle during MUL step 2 -> next cycle in_ready=1, out_valid=0, p=0, busy=0; no stale result later.
REQ-035 All 65536 (a,b) pairs with random out_ready backpressure -> every p equals a*b, results in issue order, none lost or duplicated.
